// File: rtl/pool_out_writer_pkg.sv
// Shared constants for the pooling output writer: FSM encodings and
// the packed-word byte-size helper used by the address generator.
package pool_out_writer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bytes occupied in memory by one packed word.
  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 32'd8;
  endfunction

endpackage

// File: rtl/pool_out_writer_fifo.sv
// Input buffer for the pooling output writer. First-word-fall-through FIFO:
// the head entry is visible on pop_data_o whenever empty_o is low.
// Pushes while full and pops while empty are ignored.
module pool_out_writer_fifo #(
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [FIFO_ADDR_WIDTH:0] wr_ptr_q;
  logic [FIFO_ADDR_WIDTH:0] rd_ptr_q;
  logic                     do_push;
  logic                     do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_o  = (wr_ptr_q[FIFO_ADDR_WIDTH] != rd_ptr_q[FIFO_ADDR_WIDTH]) &&
                   (wr_ptr_q[FIFO_ADDR_WIDTH-1:0] == rd_ptr_q[FIFO_ADDR_WIDTH-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign pop_data_o = mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];

  // Pointer update; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/pool_out_writer.sv
// Pooling output writer: buffers packed pooled words, then writes them to
// a strided output feature map tile (rows x words_per_row) over a
// valid/ready write port, pulsing done when the tile is complete.
module pool_out_writer
  import pool_out_writer_pkg::*;
#(
  parameter int OP_WIDTH        = 16,
  parameter int NUM_PE          = 4,
  parameter int DATA_WIDTH      = OP_WIDTH * NUM_PE,
  parameter int ADDR_WIDTH      = 32,
  parameter int DIM_WIDTH       = 10,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [DIM_WIDTH-1:0]  cfg_words_per_row,
  input  logic [DIM_WIDTH-1:0]  cfg_num_rows,
  input  logic [ADDR_WIDTH-1:0] cfg_row_stride,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_req,
  input  logic                  wr_ready
);

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);

  logic [1:0]            state_q,      state_d;
  logic [DIM_WIDTH-1:0]  wpr_q,        wpr_d;
  logic [DIM_WIDTH-1:0]  rows_q,       rows_d;
  logic [ADDR_WIDTH-1:0] stride_q,     stride_d;
  logic [ADDR_WIDTH-1:0] row_base_q,   row_base_d;
  logic [DIM_WIDTH-1:0]  word_idx_q,   word_idx_d;
  logic [DIM_WIDTH-1:0]  row_idx_q,    row_idx_d;
  logic                  all_loaded_q, all_loaded_d;
  logic                  overflow_q,   overflow_d;
  logic                  wr_req_q,     wr_req_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q,    wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q,    wr_data_d;

  logic [DATA_WIDTH-1:0] fifo_data_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  load_s;
  logic                  hs_s;
  logic                  row_end_s;
  logic                  tile_end_s;
  logic [ADDR_WIDTH-1:0] word_off_s;

  pool_out_writer_fifo #(
    .DATA_WIDTH      (DATA_WIDTH),
    .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (in_valid),
    .push_data_i (in_data),
    .pop_i       (load_s),
    .pop_data_o  (fifo_data_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  // Output register reloads whenever it is free or being drained this cycle,
  // which allows one write per cycle while wr_ready stays high.
  assign load_s     = (state_q == ST_RUN) && (!wr_req_q || wr_ready) &&
                      !fifo_empty_s && !all_loaded_q;
  assign hs_s       = wr_req_q && wr_ready;
  assign row_end_s  = (word_idx_q == (wpr_q - {{(DIM_WIDTH-1){1'b0}}, 1'b1}));
  assign tile_end_s = row_end_s && (row_idx_q == (rows_q - {{(DIM_WIDTH-1){1'b0}}, 1'b1}));
  assign word_off_s = ADDR_WIDTH'(word_idx_q) * ADDR_WIDTH'(BYTES_PER_WORD);

  // Next-state logic for the FSM, address generator and output register.
  always_comb begin
    state_d      = state_q;
    wpr_d        = wpr_q;
    rows_d       = rows_q;
    stride_d     = stride_q;
    row_base_d   = row_base_q;
    word_idx_d   = word_idx_q;
    row_idx_d    = row_idx_q;
    all_loaded_d = all_loaded_q;
    overflow_d   = overflow_q;
    wr_req_d     = wr_req_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          wpr_d        = cfg_words_per_row;
          rows_d       = cfg_num_rows;
          stride_d     = cfg_row_stride;
          row_base_d   = cfg_base_addr;
          word_idx_d   = '0;
          row_idx_d    = '0;
          all_loaded_d = 1'b0;
          overflow_d   = 1'b0;
          if ((cfg_words_per_row == '0) || (cfg_num_rows == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (load_s) begin
          wr_req_d  = 1'b1;
          wr_data_d = fifo_data_s;
          wr_addr_d = row_base_q + word_off_s;
          if (row_end_s) begin
            word_idx_d = '0;
            row_idx_d  = row_idx_q + {{(DIM_WIDTH-1){1'b0}}, 1'b1};
            row_base_d = row_base_q + stride_q;
          end else begin
            word_idx_d = word_idx_q + {{(DIM_WIDTH-1){1'b0}}, 1'b1};
          end
          if (tile_end_s) begin
            all_loaded_d = 1'b1;
          end else begin
            all_loaded_d = all_loaded_q;
          end
        end else if (hs_s) begin
          wr_req_d = 1'b0;
        end else begin
          wr_req_d = wr_req_q;
        end
        // Once every word is loaded, the only outstanding write is the last.
        if (hs_s && all_loaded_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Producer ignores backpressure: a word arriving on a full FIFO is lost.
    overflow_d = overflow_d | (in_valid & fifo_full_s);
  end

  // State, configuration, counters and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wpr_q        <= '0;
      rows_q       <= '0;
      stride_q     <= '0;
      row_base_q   <= '0;
      word_idx_q   <= '0;
      row_idx_q    <= '0;
      all_loaded_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wpr_q        <= wpr_d;
      rows_q       <= rows_d;
      stride_q     <= stride_d;
      row_base_q   <= row_base_d;
      word_idx_q   <= word_idx_d;
      row_idx_q    <= row_idx_d;
      all_loaded_q <= all_loaded_d;
      overflow_q   <= overflow_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign overflow = overflow_q;
  assign in_ready = !fifo_full_s;
  assign wr_req   = wr_req_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_pool_out_writer.sv
// Directed testbench for pool_out_writer. Inputs change 1 time unit after
// the rising edge; outputs are checked there or sampled on the falling edge.
module tb_pool_out_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] cfg_base_addr;
  logic [9:0]  cfg_words_per_row;
  logic [9:0]  cfg_num_rows;
  logic [31:0] cfg_row_stride;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic        wr_req;
  logic        wr_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] hs_addr_q[$];
  logic [63:0] hs_data_q[$];
  int          done_cnt = 0;
  int          req_cnt  = 0;

  always #5 clk = ~clk;

  pool_out_writer dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .cfg_base_addr     (cfg_base_addr),
    .cfg_words_per_row (cfg_words_per_row),
    .cfg_num_rows      (cfg_num_rows),
    .cfg_row_stride    (cfg_row_stride),
    .busy              (busy),
    .done              (done),
    .overflow          (overflow),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_req            (wr_req),
    .wr_ready          (wr_ready)
  );

  // Record every completed write and count done / request cycles.
  always @(negedge clk) begin
    if (wr_req === 1'b1 && wr_ready === 1'b1) begin
      hs_addr_q.push_back(wr_addr);
      hs_data_q.push_back(wr_data);
    end
    if (done === 1'b1) done_cnt++;
    if (wr_req === 1'b1) req_cnt++;
  end

  function automatic logic [63:0] word_of(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    hs_addr_q.delete();
    hs_data_q.delete();
    done_cnt = 0;
    req_cnt  = 0;
  endtask

  task automatic set_cfg(input logic [31:0] base, input logic [9:0] wpr,
                         input logic [9:0] rows, input logic [31:0] stride);
    cfg_base_addr     = base;
    cfg_words_per_row = wpr;
    cfg_num_rows      = rows;
    cfg_row_stride    = stride;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (wr_req !== 1'b0 || wr_addr !== 32'h0 || wr_data !== 64'h0) begin
      $display("FAIL reset_wr: req=%b addr=%h data=%h, required 0/0/0", wr_req, wr_addr, wr_data);
      errors++;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL reset_status: busy=%b done=%b ovf=%b, required 0/0/0", busy, done, overflow);
      errors++;
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      errors++;
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_addr [4];
    int n;
    exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1008;
    exp_addr[2] = 32'h1100; exp_addr[3] = 32'h1108;
    clear_log();
    wr_ready = 1'b1;
    set_cfg(32'h1000, 10'd2, 10'd2, 32'h100);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL basic_busy: got %b, required 1", busy);
      errors++;
    end
    in_valid = 1'b1;
    in_data  = word_of(0);
    tick();
    checks++;
    if (wr_req !== 1'b0) begin
      $display("FAIL basic_latency_early: wr_req=%b one cycle after accept, required 0", wr_req);
      errors++;
    end
    in_data = word_of(1);
    tick();
    checks++;
    if (wr_req !== 1'b1 || wr_addr !== 32'h1000 || wr_data !== word_of(0)) begin
      $display("FAIL basic_latency: req=%b addr=%h data=%h, required 1/00001000/%h",
               wr_req, wr_addr, wr_data, word_of(0));
      errors++;
    end
    in_data = word_of(2);
    tick();
    in_data = word_of(3);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL basic_done_timeout: done=%b after %0d cycles, required 1", done, n);
      errors++;
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt != 1) begin
      $display("FAIL basic_done_pulse: done=%b busy=%b pulses=%0d, required 0/0/1", done, busy, done_cnt);
      errors++;
    end
    checks++;
    if (hs_addr_q.size() != 4) begin
      $display("FAIL basic_count: got %0d writes, required 4", hs_addr_q.size());
      errors++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (hs_addr_q[i] !== exp_addr[i] || hs_data_q[i] !== word_of(i)) begin
          $display("FAIL basic_write%0d: addr=%h data=%h, required %h/%h",
                   i, hs_addr_q[i], hs_data_q[i], exp_addr[i], word_of(i));
          errors++;
        end
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      $display("FAIL basic_overflow: got %b, required 0", overflow);
      errors++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    clear_log();
    wr_ready = 1'b0;
    set_cfg(32'h2000, 10'd3, 10'd1, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = word_of(10 + i);
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (wr_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (wr_req !== 1'b1 || wr_addr !== 32'h2000 || wr_data !== word_of(10)) begin
        $display("FAIL bp_hold%0d: req=%b addr=%h data=%h, required 1/00002000/%h",
                 c, wr_req, wr_addr, wr_data, word_of(10));
        errors++;
      end
      tick();
    end
    wr_ready = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL bp_done_timeout: done=%b, required 1", done);
      errors++;
    end
    checks++;
    if (hs_addr_q.size() != 3) begin
      $display("FAIL bp_count: got %0d writes, required 3", hs_addr_q.size());
      errors++;
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (hs_addr_q[i] !== 32'h2000 + 32'(8 * i) || hs_data_q[i] !== word_of(10 + i)) begin
          $display("FAIL bp_write%0d: addr=%h data=%h, required %h/%h",
                   i, hs_addr_q[i], hs_data_q[i], 32'h2000 + 32'(8 * i), word_of(10 + i));
          errors++;
        end
      end
    end
    tick();
  endtask

  task automatic test_overflow();
    int n;
    clear_log();
    wr_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = word_of(20 + i);
      tick();
      if (i == 15) begin
        checks++;
        if (in_ready !== 1'b0 || overflow !== 1'b0) begin
          $display("FAIL ovf_full: in_ready=%b overflow=%b after 16 words, required 0/0", in_ready, overflow);
          errors++;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL ovf_set: overflow=%b in_ready=%b, required 1/0", overflow, in_ready);
      errors++;
    end
    // Start clears the sticky flag; then push while the first pop happens.
    set_cfg(32'h3000, 10'd16, 10'd1, 32'h0);
    wr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (overflow !== 1'b0 || wr_req !== 1'b0) begin
      $display("FAIL ovf_clear: overflow=%b wr_req=%b, required 0/0", overflow, wr_req);
      errors++;
    end
    in_valid = 1'b1;
    in_data  = word_of(99);
    tick();
    in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || in_ready !== 1'b1 || wr_data !== word_of(20) || wr_addr !== 32'h3000) begin
      $display("FAIL ovf_push_pop: overflow=%b in_ready=%b addr=%h data=%h, required 1/1/00003000/%h",
               overflow, in_ready, wr_addr, wr_data, word_of(20));
      errors++;
    end
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL ovf_done_timeout: done=%b, required 1", done);
      errors++;
    end
    checks++;
    if (hs_addr_q.size() != 16) begin
      $display("FAIL ovf_count: got %0d writes, required 16", hs_addr_q.size());
      errors++;
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (hs_addr_q[i] !== 32'h3000 + 32'(8 * i) || hs_data_q[i] !== word_of(20 + i)) begin
          $display("FAIL ovf_write%0d: addr=%h data=%h, required %h/%h",
                   i, hs_addr_q[i], hs_data_q[i], 32'h3000 + 32'(8 * i), word_of(20 + i));
          errors++;
        end
      end
    end
    tick();
  endtask

  task automatic test_zero_size();
    clear_log();
    wr_ready = 1'b1;
    set_cfg(32'h5000, 10'd2, 10'd0, 32'h100);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL zero_done: done=%b busy=%b, required 1/1", done, busy);
      errors++;
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL zero_idle: done=%b busy=%b, required 0/0", done, busy);
      errors++;
    end
    tick();
    checks++;
    if (req_cnt != 0) begin
      $display("FAIL zero_no_write: %0d wr_req cycles, required 0", req_cnt);
      errors++;
    end
  endtask

  task automatic test_wrap();
    int n;
    clear_log();
    wr_ready = 1'b1;
    set_cfg(32'hFFFF_FFF8, 10'd2, 10'd1, 32'h40);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = word_of(30 + i);
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (hs_addr_q.size() != 2) begin
      $display("FAIL wrap_count: got %0d writes, required 2", hs_addr_q.size());
      errors++;
    end else begin
      checks++;
      if (hs_addr_q[0] !== 32'hFFFF_FFF8 || hs_addr_q[1] !== 32'h0000_0000) begin
        $display("FAIL wrap_addr: got %h %h, required fffffff8 00000000", hs_addr_q[0], hs_addr_q[1]);
        errors++;
      end
    end
    tick();
  endtask

  task automatic test_reset_midjob();
    int n;
    clear_log();
    wr_ready = 1'b0;
    set_cfg(32'h4000, 10'd4, 10'd1, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = word_of(40 + i);
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (wr_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    wr_ready = 1'b1;
    tick();
    reset    = 1'b1;
    wr_ready = 1'b0;
    tick();
    checks++;
    if (hs_addr_q.size() != 1) begin
      $display("FAIL rst_mid_progress: %0d writes before reset, required 1", hs_addr_q.size());
      errors++;
    end
    checks++;
    if (wr_req !== 1'b0 || wr_addr !== 32'h0 || wr_data !== 64'h0 ||
        busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL rst_mid_outputs: req=%b addr=%h data=%h busy=%b done=%b ovf=%b rdy=%b, required reset values",
               wr_req, wr_addr, wr_data, busy, done, overflow, in_ready);
      errors++;
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (done_cnt != 0) begin
      $display("FAIL rst_mid_no_done: %0d done cycles, required 0", done_cnt);
      errors++;
    end
    clear_log();
    wr_ready = 1'b1;
    set_cfg(32'h4000, 10'd1, 10'd1, 32'h0);
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = word_of(50);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (hs_addr_q.size() != 1) begin
      $display("FAIL rst_restart_count: got %0d writes, required 1", hs_addr_q.size());
      errors++;
    end else begin
      checks++;
      if (hs_addr_q[0] !== 32'h4000 || hs_data_q[0] !== word_of(50)) begin
        $display("FAIL rst_restart_write: addr=%h data=%h, required 00004000/%h",
                 hs_addr_q[0], hs_data_q[0], word_of(50));
        errors++;
      end
    end
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 64'h0;
    wr_ready = 1'b0;
    set_cfg(32'h0, 10'd0, 10'd0, 32'h0);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_zero_size();
    test_wrap();
    test_reset_midjob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
